// File: rtl/timer_pkg.sv
// Shared types and default sizes for the 4-bit down timer and its prescaler.
package timer_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int PSC_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick fires every psc+1 cycles, restarted from 0 by clear.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             clear,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] r_cnt;

  // clear also masks tick so a restart edge never counts as a tick
  assign tick = !clear && (r_cnt == psc);

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b)             r_cnt <= '0;
    else if (clear || tick) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/down_timer_4b.sv
// Prescaled down counter with one-shot/periodic modes, tc pulse and sticky expired flag.
module down_timer_4b
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PSC_W-1:0] prescale,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic [PSC_W-1:0] r_psc, w_psc_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_expired, w_expired_nxt;
  logic             r_busy;
  logic             w_clear;
  logic             w_tick;

  // Prescaler only runs undisturbed in RUN; any stop/start restarts it from 0.
  assign w_clear = stop || start || (r_state != RUN);

  tick_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk   (clk),
    .clr_b (clr_b),
    .clear (w_clear),
    .psc   (r_psc),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_psc_nxt     = r_psc;
    w_mode_nxt    = r_mode;
    w_tc_nxt      = 1'b0;
    w_expired_nxt = ack ? 1'b0 : r_expired;

    if (stop) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      w_state_nxt  = RUN;
      w_count_nxt  = load_val;
      w_reload_nxt = load_val;
      w_psc_nxt    = prescale;
      w_mode_nxt   = periodic;
    end else if (r_state == RUN && w_tick) begin
      if (r_count != '0) begin
        w_count_nxt = r_count - 1'b1;
      end else begin
        // terminal tick: expiry beats a same-cycle ack
        w_tc_nxt      = 1'b1;
        w_expired_nxt = 1'b1;
        if (r_mode) w_count_nxt = r_reload;
        else        w_state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_psc     <= '0;
      r_mode    <= 1'b0;
      r_tc      <= 1'b0;
      r_expired <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_psc     <= w_psc_nxt;
      r_mode    <= w_mode_nxt;
      r_tc      <= w_tc_nxt;
      r_expired <= w_expired_nxt;
      r_busy    <= (w_state_nxt == RUN);
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

// File: doc/down_timer_4b.md
DOWN_TIMER_4B -- requirements
Module: down_timer_4b

Interface
REQ-001 Parameter WIDTH, default 4, counter and load width in bits.
REQ-002 Parameter PSC_W, default 4, prescaler register width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_b  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level sampled each edge; loads load_val/prescale and runs.
REQ-006 stop  input  1  level sampled each edge; halts timer and returns to IDLE.
REQ-007 periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled only with start.
REQ-008 load_val  input  WIDTH  start value for the down count.
REQ-009 prescale  input  PSC_W  tick divider; one tick every prescale+1 cycles.
REQ-010 ack  input  1  clears the sticky expired flag.
REQ-011 count  output  WIDTH  current count value, registered.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle per expiry.
REQ-013 busy  output  1  high while state is RUN.
REQ-014 expired  output  1  sticky expiry flag.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: count holds; start=1 -> count<=load_val, reload_reg<=load_val, psc_reg<=prescale, mode_reg<=periodic, psc_cnt<=0, next RUN.
REQ-017 RUN: tick SHALL occur on edges where psc_cnt==psc_reg; psc_cnt then returns to 0, otherwise increments.
REQ-018 RUN, tick, count!=0 -> count<=count-1.
REQ-019 RUN, tick, count==0 -> tc<=1 for one cycle, expired<=1; mode_reg=1 -> count<=reload_reg, stay RUN; mode_reg=0 -> count stays 0, next DONE.
REQ-020 Period between tc pulses: (load_val+1)*(prescale+1) cycles; load_val=0 is legal.
REQ-021 start in RUN or DONE SHALL restart exactly as REQ-016 (reload, psc_cnt<=0, next RUN).
REQ-022 stop in any state -> next IDLE, count holds, psc_cnt<=0, tc<=0; stop has priority over start and over a same-cycle tick.
REQ-023 tc SHALL be 0 on every edge that is not a terminal tick.
REQ-024 ack=1 clears expired; a same-cycle expiry SHALL win (expired stays 1).
REQ-025 busy SHALL equal (state==RUN), decoded from registered state.
REQ-026 Count arithmetic is unsigned modulo 2^WIDTH; no decrement below 0 ever occurs.

Reset
REQ-027 clr_b=0 SHALL immediately, without a clock edge, force state=IDLE, count=0, tc=0, expired=0, busy=0, psc_cnt=0, reload_reg=0, psc_reg=0, mode_reg=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the count; no tc is produced for the abandoned run.
REQ-029 After clr_b deasserts, the first edge is handled as IDLE.

Structure
REQ-030 Package timer_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and default WIDTH/PSC_W constants.
REQ-031 Prescaler SHALL be a sub-module tick_prescaler (ports clk, clr_b, clear, psc, tick), instantiated once.
REQ-032 All outputs SHALL be driven directly from flops.

Verification
REQ-033 load_val=3, prescale=0, periodic=0, 1-cycle start -> count 3,2,1,0 on successive cycles, tc=1 exactly on the 4th edge after start, then DONE, busy=0, expired=1, count=0.
REQ-034 load_val=2, prescale=1, periodic=1 -> count 2,2,1,1,0,0,2,...; tc pulses every 6 cycles; busy stays 1.
REQ-035 RUN with count=5, start and stop together -> IDLE, count holds 5, busy=0, no tc.
REQ-036 expired=1, ack asserted on the same edge as a new terminal tick -> expired remains 1; ack alone on the next cycle -> expired=0.
REQ-037 clr_b driven low between edges during RUN at count=7 -> count, tc, busy, expired read 0 before the next edge.
REQ-038 load_val=0, prescale=0, periodic=1 -> tc=1 on every cycle after start until stop; stop -> tc=0 on the next cycle.
